// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int MEM_ADDR_W = 22;
  localparam int MEM_DATA_W = 32;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latched operation of the access in flight.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the load/store unit (master) and the responder (slave).
//
// Handshake: the master raises exactly one of memread/memwrite and holds it,
// with memaddress/memin, until it sees memready high; it must drop the strobe
// in that memready cycle. The slave samples the request once, on the edge it
// accepts it, and ignores later bus changes for that access. memerr pulses
// with memready for an out-of-range access, and on its own (no access) while
// both strobes are high in IDLE. membusy is high while an access is in flight.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic [MEM_ADDR_W-1:0] memaddress;
  logic [MEM_DATA_W-1:0] memin;
  logic                  memread;
  logic                  memwrite;
  logic [MEM_DATA_W-1:0] memout;
  logic                  memready;
  logic                  memerr;
  logic                  membusy;

  modport master (
    output memaddress, memin, memread, memwrite,
    input  memout, memready, memerr, membusy
  );

  modport slave (
    input  memaddress, memin, memread, memwrite,
    output memout, memready, memerr, membusy
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic [ADDR_BITS-1:0]  addr_i,
  input  logic [MEM_DATA_W-1:0] wdata_i,
  input  logic                  we_i,
  output logic [MEM_DATA_W-1:0] rdata_o
);

  logic [MEM_DATA_W-1:0] mem_q [2**ADDR_BITS];

  // Commit a write on the access edge; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write at a time, waits a fixed
// number of cycles, then completes with a one-cycle memready pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output state_t            dbg_state_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state_q,  state_d;
  logic [3:0]            cnt_q,    cnt_d;
  logic [MEM_ADDR_W-1:0] addr_q,   addr_d;
  logic [MEM_DATA_W-1:0] data_q,   data_d;
  op_t                   op_q,     op_d;
  logic [MEM_DATA_W-1:0] memout_q, memout_d;
  logic                  ready_q,  ready_d;
  logic                  err_q,    err_d;

  logic                  ram_we;
  logic [MEM_DATA_W-1:0] ram_rdata;
  logic                  out_of_range;

  // Any latched address bit above the implemented range makes the access illegal.
  assign out_of_range = (addr_q >> ADDR_BITS) != '0;

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .addr_i  (addr_q[ADDR_BITS-1:0]),
    .wdata_i (data_q),
    .we_i    (ram_we),
    .rdata_o (ram_rdata)
  );

  // State, counter, request latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= OP_RD;
      memout_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      memout_q <= memout_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, perform access when cnt hits 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    memout_d = memout_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.memread && bus.memwrite) begin
          // Malformed request: flag it and stay idle, repeating while held.
          err_d = 1'b1;
        end else if (bus.memread || bus.memwrite) begin
          addr_d  = bus.memaddress;
          data_d  = bus.memin;
          op_d    = bus.memwrite ? OP_WR : OP_RD;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = RESP;
          if (out_of_range) begin
            // Never alias onto the array; reads of illegal addresses return 0.
            err_d = 1'b1;
            if (op_q == OP_RD) begin
              memout_d = '0;
            end
          end else if (op_q == OP_WR) begin
            ram_we = 1'b1;
          end else begin
            memout_d = ram_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.memout   = memout_q;
  assign bus.memready = ready_q;
  assign bus.memerr   = err_q;
  assign bus.membusy  = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A uses WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  // Clock/reset block.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();
  state_t dbg_a, dbg_b;

  logic [21:0] t_addr [2];
  logic [31:0] t_din  [2];
  logic        t_rd   [2];
  logic        t_wr   [2];
  logic [31:0] o_out  [2];
  logic        o_rdy  [2];
  logic        o_err  [2];
  logic        o_busy [2];

  assign a_if.memaddress = t_addr[0];
  assign a_if.memin      = t_din[0];
  assign a_if.memread    = t_rd[0];
  assign a_if.memwrite   = t_wr[0];
  assign b_if.memaddress = t_addr[1];
  assign b_if.memin      = t_din[1];
  assign b_if.memread    = t_rd[1];
  assign b_if.memwrite   = t_wr[1];
  assign o_out[0]  = a_if.memout;
  assign o_rdy[0]  = a_if.memready;
  assign o_err[0]  = a_if.memerr;
  assign o_busy[0] = a_if.membusy;
  assign o_out[1]  = b_if.memout;
  assign o_rdy[1]  = b_if.memready;
  assign o_err[1]  = b_if.memerr;
  assign o_busy[1] = b_if.membusy;

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (a_if),
    .dbg_state_o (dbg_a)
  );

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (b_if),
    .dbg_state_o (dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver: one full access on instance sel, checking latency and the response cycle.
  task automatic do_access(input int sel, input bit is_wr, input logic [21:0] a,
                           input logic [31:0] d, input logic [31:0] exp_out,
                           input bit exp_err, input int exp_lat, input string tag,
                           output int rcyc);
    int c;
    t_addr[sel] = a;
    t_din[sel]  = d;
    t_rd[sel]   = !is_wr;
    t_wr[sel]   = is_wr;
    @(posedge clk); #1;
    check({tag, ".busy_after_accept"}, 32'(o_busy[sel]), 32'd1);
    // Scramble the bus while the strobe is held; the latched request must win.
    t_addr[sel] = ~a;
    t_din[sel]  = ~d;
    c = 0;
    while (c < 40) begin
      @(posedge clk); #1;
      c++;
      if (o_rdy[sel]) break;
    end
    rcyc = cyc;
    check({tag, ".latency"}, 32'(c), 32'(exp_lat));
    check({tag, ".memout_ready"}, o_out[sel], exp_out);
    check({tag, ".memerr_ready"}, 32'(o_err[sel]), 32'(exp_err));
    t_rd[sel] = 1'b0;
    t_wr[sel] = 1'b0;
    @(posedge clk); #1;
    check({tag, ".ready_cleared"}, 32'(o_rdy[sel]), 32'd0);
    check({tag, ".err_cleared"}, 32'(o_err[sel]), 32'd0);
    check({tag, ".busy_cleared"}, 32'(o_busy[sel]), 32'd0);
    check({tag, ".memout_hold"}, o_out[sel], exp_out);
  endtask

  initial begin
    int r1, r2;
    for (int i = 0; i < 2; i++) begin
      t_addr[i] = '0; t_din[i] = '0; t_rd[i] = 1'b0; t_wr[i] = 1'b0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.memout", o_out[0], 32'd0);
    check("rst.ready", 32'(o_rdy[0]), 32'd0);
    check("rst.err", 32'(o_err[0]), 32'd0);
    check("rst.busy", 32'(o_busy[0]), 32'd0);
    check("rst.state", 32'(dbg_a), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read back; memout untouched by the write.
    do_access(0, 1'b1, 22'h005, 32'hDEADBEEF, 32'h0, 1'b0, 3, "wr005", r1);
    do_access(0, 1'b0, 22'h005, 32'h0, 32'hDEADBEEF, 1'b0, 3, "rd005", r2);
    check("a.throughput", 32'(r2 - r1), 32'd5);

    // Out-of-range accesses must not alias onto 0x3FF.
    do_access(0, 1'b1, 22'h3FF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 3, "wr3ff", r1);
    do_access(0, 1'b1, 22'h3FFFFF, 32'hBADBAD00, 32'hDEADBEEF, 1'b1, 3, "wr_oor", r1);
    do_access(0, 1'b0, 22'h3FFFFF, 32'h0, 32'h0, 1'b1, 3, "rd_oor", r1);
    do_access(0, 1'b0, 22'h3FF, 32'h0, 32'hCAFEF00D, 1'b0, 3, "rd3ff", r1);

    // Both strobes: memerr each cycle, no access started.
    t_rd[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 22'h005;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("both.err", 32'(o_err[0]), 32'd1);
      check("both.ready", 32'(o_rdy[0]), 32'd0);
      check("both.busy", 32'(o_busy[0]), 32'd0);
    end
    t_rd[0] = 1'b0; t_wr[0] = 1'b0;
    @(posedge clk); #1;
    check("both.err_clear", 32'(o_err[0]), 32'd0);
    check("both.busy_after", 32'(o_busy[0]), 32'd0);

    // Reset mid-access aborts the pending write.
    do_access(0, 1'b1, 22'h00A, 32'h11111111, 32'hCAFEF00D, 1'b0, 3, "wr00a", r1);
    do_access(0, 1'b0, 22'h005, 32'h0, 32'hDEADBEEF, 1'b0, 3, "rd005b", r1);
    t_addr[0] = 22'h00A; t_din[0] = 32'h12345678; t_wr[0] = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 32'(o_busy[0]), 32'd1);
    @(posedge clk); #1;
    check("abort.state_wait", 32'(dbg_a), 32'(WAIT));
    t_wr[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("abort.memout", o_out[0], 32'd0);
    check("abort.busy0", 32'(o_busy[0]), 32'd0);
    check("abort.ready0", 32'(o_rdy[0]), 32'd0);
    check("abort.state", 32'(dbg_a), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_access(0, 1'b0, 22'h00A, 32'h0, 32'h11111111, 1'b0, 3, "rd00a", r1);

    // Zero-wait instance: 1-cycle latency, back-to-back reads 3 cycles apart.
    do_access(1, 1'b1, 22'h001, 32'hA1A1A1A1, 32'h0, 1'b0, 1, "b.wr001", r1);
    do_access(1, 1'b1, 22'h002, 32'hB2B2B2B2, 32'h0, 1'b0, 1, "b.wr002", r1);
    do_access(1, 1'b0, 22'h001, 32'h0, 32'hA1A1A1A1, 1'b0, 1, "b.rd001", r1);
    do_access(1, 1'b0, 22'h002, 32'h0, 32'hB2B2B2B2, 1'b0, 1, "b.rd002", r2);
    check("b.pulse_spacing", 32'(r2 - r1), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the load/store path. It sits on the far side of the memaddress/memin/memout/memread/memwrite bus driven by the load/store unit. It accepts one read or write strobe at a time, models a fixed programmable access latency, and completes every access with a one-cycle memready pulse; reads also return data on memout. Out-of-range and malformed requests are flagged on memerr rather than silently dropped.

## Interface
- ADDR_BITS, default 10: implemented word-address bits; array depth 2^ADDR_BITS words of 32 bits; legal range 1..22.
- WAIT_CYCLES, default 2: extra wait cycles per access; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- memaddress  in  22  word address of the request.
- memin  in  32  write data.
- memread  in  1  read strobe; level, held by the initiator until memready.
- memwrite  in  1  write strobe; level, held by the initiator until memready.
- memout  out  32  read data, registered.
- memready  out  1  one-cycle completion pulse.
- memerr  out  1  one-cycle error pulse.
- membusy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Counter cnt is 4 bits.
- IDLE, memread XOR memwrite at a rising edge:
  - Latch address, data and operation.
  - Set cnt to WAIT_CYCLES and go to WAIT.
  - The latched copies are used for the rest of the access; bus changes after acceptance are ignored.
- IDLE, memread AND memwrite both high:
  - memerr pulses for one cycle.
  - No access is started; stay in IDLE.
  - The pulse repeats every cycle while both strobes stay high.
- WAIT, cnt nonzero: decrement cnt on each edge.
- WAIT, cnt == 0: perform the access at this edge, assert memready, go to RESP.
  - Write: array[addr] is loaded with the latched data. memout is unchanged.
  - Read: memout is loaded with array[addr].
  - Out-of-range address (address[21:ADDR_BITS] != 0): no array write; a read returns 0 on memout; memerr is asserted together with memready.
- RESP: lasts one cycle. Clear memready and memerr, go to IDLE.
- memout holds the last completed read value until the next read completes.
- Strobes seen while in WAIT or RESP are ignored.
- The initiator must drop its strobe in the memready cycle. A strobe still high in the next IDLE cycle is accepted as a new request.

## Timing
- Request accepted at edge N. The access happens at edge N+WAIT_CYCLES+1. memready is high from that edge until edge N+WAIT_CYCLES+2.
- Total latency from acceptance to memready is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 it is 1 cycle.
- Throughput: one access per WAIT_CYCLES+3 cycles. This is the accept cycle, the WAIT cycles and RESP, with the strobe re-asserted in IDLE.
- membusy is decoded from the state register. It goes high in the cycle after acceptance and low in the cycle after RESP.
- Reset values: state IDLE, cnt 0, memout 0, memready 0, memerr 0, membusy 0. Array contents are not reset; they stay undefined until written.
- Reset asserted mid-access: the access is aborted and outputs return to reset values asynchronously. A pending write is not committed unless its access edge has already occurred.

## Structure
- Shared package dmem_pkg holds:
  - MEM_ADDR_W=22 and MEM_DATA_W=32;
  - the state enumeration IDLE/WAIT/RESP;
  - the op encoding OP_RD=0, OP_WR=1.
- One sub-module, dmem_array: single-port synchronous RAM (addr, wdata, we, rdata). It is parameterised by ADDR_BITS and contains no reset logic.
- The FSM, counter, latches and range check live in dmem_responder.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x005 (WAIT_CYCLES=2). Required: memready high exactly 3 cycles after acceptance, for one cycle; memout stays 0; memerr stays 0.
- Read address 0x005 after that write. Required: memout=0xDEADBEEF in the memready cycle, and it holds there afterwards.
- Read address 0x3FFFFF with ADDR_BITS=10. Required: memready and memerr pulse together; memout=0. A subsequent read of address 0x3FF returns the prior array value, i.e. no aliasing write occurred.
- Hold memread and memwrite both high for 2 cycles. Required: memerr high for both cycles; memready never asserts; membusy stays 0.
- Accept a write of 0x12345678 to address 0x00A, then assert rst during WAIT and release it. Required: outputs return to 0 at once, and a later read of 0x00A does not return 0x12345678.
- WAIT_CYCLES=0, back-to-back reads of 0x001 and 0x002 with the strobe re-asserted in IDLE. Required: each memready comes 1 cycle after its acceptance, and the two pulses are 3 cycles apart.
